// File: rtl/signed_cnt_pkg.sv
// Shared op-code and signed range helpers for the signed up/down counter.
// Optional macro SIGNED_CNT_SAT_EN selects saturating arithmetic in signed_cnt_addsub.
package signed_cnt_pkg;

    // Encoding matches the {up, dn} pair so decode is a plain cast.
    typedef enum logic [1:0] {
        HOLD = 2'b00,
        DEC  = 2'b01,
        INC  = 2'b10,
        LOAD = 2'b11
    } op_e;

    function automatic op_e decode_op(input logic up, input logic dn);
        return op_e'({up, dn});
    endfunction

    // Largest and smallest two's complement values for a w-bit word (w <= 63).
    function automatic logic signed [63:0] SMAX(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] SMIN(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/signed_cnt_addsub.sv
// WIDTH+1-bit signed add/subtract with overflow detect and wrap/saturate select.
// Saturation is built in when SIGNED_CNT_SAT_EN is defined; otherwise results wrap.
module signed_cnt_addsub
    import signed_cnt_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    input  logic             i_sub,
    output logic [WIDTH-1:0] o_res,
    output logic             o_ovf
);

    localparam logic signed [63:0] MAX64 = SMAX(WIDTH);
    localparam logic signed [63:0] MIN64 = SMIN(WIDTH);
    localparam logic [WIDTH-1:0]   MAX_W = MAX64[WIDTH-1:0];
    localparam logic [WIDTH-1:0]   MIN_W = MIN64[WIDTH-1:0];

    logic signed [WIDTH:0] w_x_ext;
    logic signed [WIDTH:0] w_y_ext;
    logic signed [WIDTH:0] w_sum;

    assign w_x_ext = {i_x[WIDTH-1], i_x};
    assign w_y_ext = {i_y[WIDTH-1], i_y};
    assign w_sum   = i_sub ? (w_x_ext - w_y_ext) : (w_x_ext + w_y_ext);

    // The extended result is out of range exactly when its top two bits disagree.
    assign o_ovf = w_sum[WIDTH] ^ w_sum[WIDTH-1];

`ifdef SIGNED_CNT_SAT_EN
    assign o_res = !o_ovf        ? w_sum[WIDTH-1:0] :
                   w_sum[WIDTH]  ? MIN_W            : MAX_W;
`else
    logic w_unused_rails;
    assign w_unused_rails = ^{MAX_W, MIN_W};
    assign o_res = w_sum[WIDTH-1:0];
`endif

endmodule

// File: rtl/signed_up_down_counter.sv
// Registered signed up/down counter with signed step and synchronous load (load wins).
// Define SIGNED_CNT_SAT_EN for saturating increment/decrement instead of wrap-around.
module signed_up_down_counter
    import signed_cnt_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             up,
    input  logic             dn,
    output logic [WIDTH-1:0] q
);

    op_e              w_op;
    logic [WIDTH-1:0] w_arith;
    logic             w_ovf;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] r_q;

    assign w_op = decode_op(up, dn);

    signed_cnt_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .i_x   (r_q),
        .i_y   (b),
        .i_sub (w_op == DEC),
        .o_res (w_arith),
        .o_ovf (w_ovf)
    );

    logic w_unused_ovf;
    assign w_unused_ovf = w_ovf;

    // NOTE: default assigned first so every path drives w_q_next; no latch is inferred.
    always_comb begin
        w_q_next = r_q;
        unique case (w_op)
            INC,
            DEC:  w_q_next = w_arith;
            LOAD: w_q_next = a;
            default: w_q_next = r_q;
        endcase
    end

    // NOTE: state uses non-blocking assignments; reset is asynchronous active-low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= '0;
        end else begin
            r_q <= w_q_next;
        end
    end

    assign q = r_q;

endmodule

// File: tb/tb_signed_up_down_counter.sv
// Directed self-checking bench for signed_up_down_counter (WIDTH=8).
// Expectations follow SIGNED_CNT_SAT_EN when the bench is compiled with it.
module tb_signed_up_down_counter;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         up;
    logic         dn;
    logic [W-1:0] q;

    int checks = 0;
    int errors = 0;

    signed_up_down_counter #(
        .WIDTH (W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .up  (up),
        .dn  (dn),
        .q   (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int exp_i);
        logic [W-1:0] exp_v;
        exp_v = W'(exp_i);
        checks++;
        assert (q === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(q), $signed(exp_v));
        end
    endtask

    task automatic drive(input logic u, input logic d, input int av, input int bv);
        up = u;
        dn = d;
        a  = W'(av);
        b  = W'(bv);
    endtask

    // Advance one edge and sample 1 ns later, away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        drive(0, 0, 0, 0);
        #1;
        check("reset_initial", 0);
        #3;
        rst = 1'b1;

        // Build q=37, then assert reset between edges.
        tick();
        drive(1, 1, 37, 0);
        tick();
        check("load_37", 37);
        drive(1, 0, 0, 5);
        #2;
        rst = 1'b0;
        #1;
        check("async_reset_midcycle", 0);
        tick();
        check("reset_hold_1", 0);
        tick();
        check("reset_hold_2", 0);

        // Release between edges; first edge is a normal update.
        drive(0, 1, 0, 1);
        rst = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check($sformatf("count_down_%0d", i), -i);
        end

        drive(1, 1, 100, 7);
        tick();
        check("load_priority_100", 100);
        drive(1, 0, 55, -3);
        tick();
        check("up_neg_step_97", 97);
        tick();
        check("up_neg_step_94", 94);
        drive(0, 0, 11, 22);
        tick();
        check("hold_94_a", 94);
        tick();
        check("hold_94_b", 94);

        drive(1, 1, 120, 0);
        tick();
        check("load_120", 120);
        drive(1, 0, 0, 10);
        tick();
`ifdef SIGNED_CNT_SAT_EN
        check("pos_ovf_1", 127);
        tick();
        check("pos_ovf_2", 127);
`else
        check("pos_ovf_1", -126);
        tick();
        check("pos_ovf_2", -116);
`endif

        drive(1, 1, -128, 0);
        tick();
        check("load_min", -128);
        drive(0, 1, 0, 1);
        tick();
`ifdef SIGNED_CNT_SAT_EN
        check("neg_ovf_min_minus_1", -128);
`else
        check("neg_ovf_min_minus_1", 127);
`endif

        drive(1, 1, -120, 0);
        tick();
        check("load_m120", -120);
        drive(0, 1, 0, 10);
        tick();
`ifdef SIGNED_CNT_SAT_EN
        check("neg_ovf_m130", -128);
`else
        check("neg_ovf_m130", 126);
`endif

        drive(1, 1, 0, 0);
        tick();
        check("load_0", 0);
        drive(0, 1, 0, -128);
        tick();
`ifdef SIGNED_CNT_SAT_EN
        check("dn_by_min", 127);
`else
        check("dn_by_min", -128);
`endif

        drive(1, 1, 127, 0);
        tick();
        check("load_max", 127);
        drive(1, 0, 0, 0);
        tick();
        check("up_b0_hold", 127);
        drive(0, 1, 0, 0);
        tick();
        check("dn_b0_hold", 127);
        drive(1, 0, 0, 1);
        tick();
`ifdef SIGNED_CNT_SAT_EN
        check("max_plus_1", 127);
`else
        check("max_plus_1", -128);
`endif

        // Loaded values are never altered, even at the rails.
        drive(1, 1, -128, 127);
        tick();
        check("load_min_unaltered", -128);
        drive(1, 0, 0, 127);
        tick();
        check("min_plus_max", -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
